pp_serializer: RTL
==================

Name: pp_serializer

Overview:
- Upstream feeder for the 8x8 multiplier column shift-register/compressor stage.
- Accepts operand pair a, b over a valid/ready handshake.
- Generates all W*W partial products a[i]&b[j] and streams them, one bit per column per clock, onto the 2W-1 serial column inputs (ser[k] drives src{k}_).
- Pulses done in the single cycle in which the downstream column registers hold the complete partial-product matrix, so dst0..dst{2W-1} equal a*b.

Parameters:
W  8  operand width; number of columns NCOL = 2W-1; tallest column height = W

Ports:
clk       input   1       clock, all state on posedge
rst       input   1       synchronous, active-high reset
in_valid  input   1       operand pair offered
in_ready  output  1       block idle and can accept
a         input   W       multiplicand
b         input   W       multiplier
ser       output  2W-1    serial column bits; bit k feeds column k shift input
busy      output  1       high during SHIFT cycles
done      output  1       one-cycle pulse: downstream compressor output valid this cycle

Behaviour:
- Reset: state IDLE, cnt 0, a_q/b_q 0, ser 0, busy 0, done 0; in_ready held 0 while rst high.
- Reset mid-operation aborts immediately: next cycle IDLE, ser 0, no done pulse.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready, capture a_q <= a, b_q <= b, cnt <= 0, go to SHIFT.
  - SHIFT: in_ready = 0, busy = 1, in_valid ignored. ser driven combinationally from a_q, b_q, cnt. cnt increments each cycle; at cnt == W-1 go to DONE.
  - DONE: done = 1 for exactly one cycle, ser 0, then IDLE.
- Throughput: one product per W+2 cycles. The handshake cycle is IDLE; the next W cycles are SHIFT; the following cycle is DONE.
- Column k:
  - height h(k) = min(k+1, 2W-1-k).
  - pair index p enumerates i = max(0, k-W+1) + p, j = k - i, for p = 0..h(k)-1.
- ser[k] in SHIFT cycle t = cnt: p = t - (W - h(k)).
  - p >= 0: ser[k] = a_q[i] & b_q[j].
  - p < 0: ser[k] = 0 (leading filler shifts out before DONE).
- ser = 0 in IDLE and DONE.
- Downstream column registers shift every clock without an enable. Compressor output equals a*b only in the DONE cycle; afterwards zeros shift in. Consumers sample on done only.
- Outputs busy, done, in_ready decode from state; ser is combinational from registered state only (no input-to-output path).
- All widths unsigned; cnt width clog2(W).

Decomposition:
- Package pp_pkg holds:
  - NCOL = 2W-1
  - state enum {IDLE, SHIFT, DONE}
  - functions col_height(k) and col_base(k) = max(0, k-W+1)
- One sub-module pp_column_mux, instantiated NCOL times via generate with column index parameter K. Inputs a_q, b_q, cnt; output one ser bit. It implements the p / i / j mapping above.

Test Plan:
- Basic product: a=0xFF, b=0xFF, hold in_valid one cycle. done rises exactly 9 cycles after the handshake edge, and dst{15..0} read as 0xFE01 in that cycle only.
- Column-7 timing: a=0xFF, b=0x01. ser[7] is 1 only in SHIFT cycle cnt=7, and ser[0] is 1 only in cnt=7. Result 0x00FF.
- Corner operands: a=0x00, b=0xA5 gives ser all zero in every cycle and result 0. Then a=0x01, b=0x01 gives only ser[0] high at cnt=7 and result 0x0001.
- Handshake: in_valid held high with changing a/b during SHIFT and DONE. The captured pair is unchanged, in_ready is 0 for W+1 cycles, and back-to-back accepts are spaced W+2 cycles apart.
- Reset mid-SHIFT: assert rst at cnt=3. The next cycle has ser=0, busy=0, and no done pulse. in_ready returns to 1 after rst drops, and a fresh pair 0x12*0x34 yields 0x03A8.
- Random regression: 1000 random a/b pairs compared against a*b on each done pulse. Check that done never occurs without a preceding accept.

Source files
------------

// File: rtl/pp_pkg.sv
// Shared types and column-geometry helpers for the partial-product serializer.
// The geometry functions take the operand width so one package serves any W.
package pp_pkg;

  localparam int W_DEFAULT = 8;
  localparam int NCOL      = 2 * W_DEFAULT - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Number of partial products landing in column k: min(k+1, 2w-1-k).
  function automatic int col_height(input int k, input int w);
    int lo;
    int hi;
    lo = k + 1;
    hi = 2 * w - 1 - k;
    return (lo < hi) ? lo : hi;
  endfunction

  // Smallest multiplicand bit index i that contributes to column k.
  function automatic int col_base(input int k, input int w);
    return (k - w + 1 > 0) ? (k - w + 1) : 0;
  endfunction

endpackage

// File: rtl/pp_column_mux.sv
// One serial column source: selects a_q[i] & b_q[j] for the pair due this SHIFT cycle.
// Short columns are right-aligned in time so every column completes on the last SHIFT cycle.
module pp_column_mux
  import pp_pkg::*;
#(
  parameter int W  = 8,
  parameter int K  = 0,
  parameter int CW = 3
) (
  input  logic          en,
  input  logic [W-1:0]  a_q,
  input  logic [W-1:0]  b_q,
  input  logic [CW-1:0] cnt,
  output logic          ser_bit
);

  localparam int H    = col_height(K, W);
  localparam int BASE = col_base(K, W);
  localparam int OFF  = W - H;

  logic [H-1:0] hits;

  // Pair p is emitted when cnt == OFF + p; earlier cycles shift leading zeros.
  for (genvar p = 0; p < H; p++) begin : g_pair
    assign hits[p] = a_q[BASE + p] & b_q[K - BASE - p] & (cnt == CW'(OFF + p));
  end

  assign ser_bit = en & (|hits);

endmodule

// File: rtl/pp_serializer.sv
// Operand-pair to column-serial partial-product feeder for the multiplier compressor.
// Handshake: a pair transfers on a rising clk edge where in_valid && in_ready are both high.
module pp_serializer
  import pp_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-2:0] ser,
  output logic           busy,
  output logic           done,
  output logic [1:0]     state_dbg
);

  localparam int NC = 2 * W - 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  a_nx;
  logic [W-1:0]  b_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      a_q   <= a_nx;
      b_q   <= b_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    a_nx     = a_q;
    b_nx     = b_q;
    case (state)
      IDLE: begin
        if (in_valid) begin
          a_nx     = a;
          b_nx     = b;
          cnt_nx   = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == CW'(W - 1)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // in_ready is forced low during reset so no pair is lost to the reset edge.
  assign in_ready  = (state == IDLE) && !rst;
  assign busy      = (state == SHIFT);
  assign done      = (state == DONE);
  assign state_dbg = state;

  for (genvar k = 0; k < NC; k++) begin : g_col
    pp_column_mux #(
      .W (W),
      .K (k),
      .CW(CW)
    ) u_col (
      .en     (busy),
      .a_q    (a_q),
      .b_q    (b_q),
      .cnt    (cnt),
      .ser_bit(ser[k])
    );
  end

endmodule
